// File: rtl/unidad_control_multiciclo_pkg.sv
// paquete_control: shared state encoding, opcodes and datapath select constants
package paquete_control;
  typedef enum logic [3:0] {
    INICIO       = 4'd0,
    FETCH        = 4'd1,
    DECODE       = 4'd2,
    DIR_MEM      = 4'd3,
    LEER_MEM     = 4'd4,
    ESCRIBIR_MEM = 4'd5,
    WB_MEM       = 4'd6,
    EJEC_R       = 4'd7,
    WB_R         = 4'd8,
    RAMA         = 4'd9,
    ERROR        = 4'd10
  } estado_t;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRC_A_PC = 2'd0;
  localparam logic [1:0] SRC_A_PC_ANT = 2'd1;
  localparam logic [1:0] SRC_A_REG = 2'd2;
  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_CUATRO = 2'd1;
  localparam logic [1:0] SRC_B_INM = 2'd2;
  localparam logic [1:0] ERR_NINGUNO = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  function automatic logic es_mem(input estado_t e);
    return e inside {FETCH, LEER_MEM, ESCRIBIR_MEM};
  endfunction
endpackage

// File: rtl/unidad_control_multiciclo_contador_espera.sv
// contador_espera: counts stalled memory cycles and flags the one that hits MAX_ESPERA
module contador_espera #(
  parameter int MAX_ESPERA = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expirado
);
  localparam int W = MAX_ESPERA > 0 ? $clog2(MAX_ESPERA + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  // expires on the stalled cycle whose increment would reach the limit
  assign expirado = (MAX_ESPERA != 0) && en && (cnt_q == W'(MAX_ESPERA - 1));
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: Moore control FSM for the multicycle RV64 datapath
module unidad_control_multiciclo
  import paquete_control::*;
#(
  parameter int ANCHO_CONT = 32,
  parameter int MAX_ESPERA = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic                  mem_listo,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  pc_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  ilegal,
  output logic [1:0]            error_cod,
  output logic [3:0]            estado,
  output logic [ANCHO_CONT-1:0] instr_retiradas
);
  estado_t estado_q, estado_d;
  logic [1:0] error_cod_q, error_cod_d;
  logic [ANCHO_CONT-1:0] instr_q, instr_d;
  logic retira, expirado, espera_en, espera_clr;
  assign espera_en = es_mem(estado_q) & ~mem_listo;
  assign espera_clr = ~es_mem(estado_q) | mem_listo;
  contador_espera #(.MAX_ESPERA(MAX_ESPERA)) u_espera (
    .clk(clk),
    .reset(reset),
    .clr(espera_clr),
    .en(espera_en),
    .expirado(expirado)
  );
  always_comb begin
    estado_d = estado_q;
    error_cod_d = error_cod_q;
    retira = 1'b0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    iord = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_src = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_REG;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    ilegal = 1'b0;
    case (estado_q)
      INICIO: estado_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = SRC_B_CUATRO;
        ir_write = mem_listo;
        pc_write = mem_listo;
        estado_d = mem_listo ? DECODE : expirado ? ERROR : FETCH;
      end
      DECODE: begin
        alu_src_a = SRC_A_PC_ANT;
        alu_src_b = SRC_B_INM;
        estado_d = (opcode == OP_LD || opcode == OP_SD) ? DIR_MEM :
                   opcode == OP_R ? EJEC_R : opcode == OP_BEQ ? RAMA : ERROR;
      end
      DIR_MEM: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_INM;
        estado_d = opcode == OP_SD ? ESCRIBIR_MEM : LEER_MEM;
      end
      LEER_MEM: begin
        mem_req = 1'b1;
        iord = 1'b1;
        estado_d = mem_listo ? WB_MEM : expirado ? ERROR : LEER_MEM;
      end
      ESCRIBIR_MEM: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        iord = 1'b1;
        retira = mem_listo;
        estado_d = mem_listo ? FETCH : expirado ? ERROR : ESCRIBIR_MEM;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        retira = 1'b1;
        estado_d = FETCH;
      end
      EJEC_R: begin
        alu_src_a = SRC_A_REG;
        alu_op = ALU_FUNCT;
        estado_d = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        retira = 1'b1;
        estado_d = FETCH;
      end
      RAMA: begin
        alu_src_a = SRC_A_REG;
        alu_op = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src = 1'b1;
        retira = 1'b1;
        estado_d = FETCH;
      end
      ERROR: ilegal = 1'b1;
      default: estado_d = INICIO;
    endcase
    // only DECODE enters ERROR for a bad opcode; every other entry is a stalled memory access
    if (estado_d == ERROR && estado_q != ERROR)
      error_cod_d = estado_q == DECODE ? ERR_OPCODE : ERR_TIMEOUT;
    instr_d = instr_q + ANCHO_CONT'(retira);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= INICIO;
      error_cod_q <= ERR_NINGUNO;
      instr_q <= '0;
    end else begin
      estado_q <= estado_d;
      error_cod_q <= error_cod_d;
      instr_q <= instr_d;
    end
  end
  assign estado = estado_q;
  assign error_cod = error_cod_q;
  assign instr_retiradas = instr_q;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: directed and random instruction streams against a per-instruction reference model
module tb_unidad_control_multiciclo;
  import paquete_control::*;
  typedef struct packed {
    logic mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0] a, b, op;
    logic reg_write, mem_to_reg, ilegal;
    logic [1:0] err;
  } ctl_t;
  logic clk = 1'b0;
  logic reset, mem_listo;
  logic [6:0] opcode;
  logic mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, error_cod;
  logic reg_write, mem_to_reg, ilegal;
  logic [3:0] estado, instr_retiradas;
  ctl_t got;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [1:0] exp_err = 2'b00;
  logic [6:0] ops [4] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011};
  assign got = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, ilegal, error_cod};
  always #5 clk = ~clk;
  unidad_control_multiciclo #(.ANCHO_CONT(4), .MAX_ESPERA(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_listo(mem_listo),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .ilegal(ilegal),
    .error_cod(error_cod), .estado(estado), .instr_retiradas(instr_retiradas)
  );
  function automatic ctl_t exp_ctl(input logic [3:0] est, input logic l);
    ctl_t c = '0;
    case (est)
      FETCH: begin c.mem_req = 1; c.b = 2'd1; c.ir_write = l; c.pc_write = l; end
      DECODE: begin c.a = 2'd1; c.b = 2'd2; end
      DIR_MEM: begin c.a = 2'd2; c.b = 2'd2; end
      LEER_MEM: begin c.mem_req = 1; c.iord = 1; end
      ESCRIBIR_MEM: begin c.mem_req = 1; c.mem_write = 1; c.iord = 1; end
      WB_MEM: begin c.reg_write = 1; c.mem_to_reg = 1; end
      EJEC_R: begin c.a = 2'd2; c.op = 2'b10; end
      WB_R: c.reg_write = 1;
      RAMA: begin c.a = 2'd2; c.op = 2'b01; c.pc_write_cond = 1; c.pc_src = 1; end
      ERROR: begin c.ilegal = 1; c.err = exp_err; end
      default: c = '0;
    endcase
    return c;
  endfunction
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction
  task automatic chk(input logic [3:0] est, input logic l);
    ctl_t e;
    logic [3:0] c;
    e = exp_ctl(est, l);
    c = 4'(exp_cnt % 16);
    checks++;
    assert (estado === est) else begin errors++; $error("FAIL estado: got %0d expected %0d", estado, est); end
    checks++;
    assert (got === e) else begin errors++; $error("FAIL ctl(est %0d): got %h expected %h", est, got, e); end
    checks++;
    assert (instr_retiradas === c) else begin errors++; $error("FAIL retired: got %0d expected %0d", instr_retiradas, c); end
  endtask
  task automatic cyc(input logic [3:0] est, input logic l, input logic [6:0] op);
    @(negedge clk);
    mem_listo = l;
    opcode = op;
    #1;
    chk(est, l);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_listo = rbit();
    @(negedge clk);
    #1;
    exp_cnt = 0;
    exp_err = 2'b00;
    chk(INICIO, mem_listo);
    reset = 1'b0;
  endtask
  task automatic run_instr(input int kind, input int wf, input int wm);
    logic [6:0] op;
    op = ops[kind];
    for (int i = 0; i < wf; i++) cyc(FETCH, 1'b0, rop());
    cyc(FETCH, 1'b1, rop());
    cyc(DECODE, rbit(), op);
    case (kind)
      0: begin
        cyc(DIR_MEM, rbit(), op);
        for (int i = 0; i < wm; i++) cyc(LEER_MEM, 1'b0, rop());
        cyc(LEER_MEM, 1'b1, rop());
        cyc(WB_MEM, rbit(), rop());
      end
      1: begin
        cyc(DIR_MEM, rbit(), op);
        for (int i = 0; i < wm; i++) cyc(ESCRIBIR_MEM, 1'b0, rop());
        cyc(ESCRIBIR_MEM, 1'b1, rop());
      end
      2: begin
        cyc(EJEC_R, rbit(), rop());
        cyc(WB_R, rbit(), rop());
      end
      default: cyc(RAMA, rbit(), rop());
    endcase
    exp_cnt++;
  endtask
  initial begin
    reset = 1'b1;
    mem_listo = 1'b0;
    opcode = 7'd0;
    do_reset();
    run_instr(2, 0, 0);
    run_instr(0, 0, 3);
    run_instr(3, 0, 0);
    run_instr(1, 3, 0);
    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int i = 0; i < 4; i++) cyc(FETCH, 1'b0, rop());
    exp_err = 2'b10;
    for (int i = 0; i < 5; i++) cyc(ERROR, rbit(), rop());
    do_reset();
    cyc(FETCH, 1'b1, rop());
    cyc(DECODE, 1'b0, ops[0]);
    cyc(DIR_MEM, 1'b0, ops[0]);
    for (int i = 0; i < 4; i++) cyc(LEER_MEM, 1'b0, rop());
    exp_err = 2'b10;
    cyc(ERROR, 1'b1, rop());
    do_reset();
    cyc(FETCH, 1'b1, rop());
    cyc(DECODE, 1'b0, ops[0]);
    cyc(DIR_MEM, 1'b0, ops[0]);
    cyc(LEER_MEM, 1'b0, rop());
    do_reset();
    run_instr(0, 3, 3);
    cyc(FETCH, 1'b1, rop());
    cyc(DECODE, rbit(), 7'b0010011);
    exp_err = 2'b01;
    for (int i = 0; i < 20; i++) cyc(ERROR, rbit(), rop());
    do_reset();
    run_instr(3, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
- Moore-style multicycle control FSM for the RV64 integer core. It sequences the shared datapath: PC, IR, register file, ALU, immediate generator and a single unified memory port.
- Supported instructions: ld (0000011), sd (0100011), beq (1100011) and R-type (0110011).
- Drives every datapath enable and mux select, and handshakes with memory.
- Detects illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- ANCHO_CONT, 32, width of the retired-instruction counter.
- MAX_ESPERA, 255, maximum cycles a memory request may wait for mem_listo. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0] from the datapath instruction register.
- mem_listo  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held until mem_listo.
- mem_write  output  1  request is a write (sd).
- iord  output  1  address select: 0=PC, 1=ALUOut.
- ir_write  output  1  load IR (and PC_ant) from memory read data.
- pc_write  output  1  unconditional PC write.
- pc_write_cond  output  1  PC write qualified by the ALU zero flag (datapath ANDs).
- pc_src  output  1  PC source: 0=ALU result, 1=ALUOut.
- alu_src_a  output  2  0=PC, 1=PC_ant, 2=register A.
- alu_src_b  output  2  0=register B, 1=constant 4, 2=Inmediato.
- alu_op  output  2  00=add, 01=sub, 10=decode funct3/funct7.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  write-back source: 0=ALUOut, 1=MDR.
- ilegal  output  1  sticky error flag.
- error_cod  output  2  00=none, 01=illegal opcode, 10=memory timeout.
- estado  output  4  current state encoding, for debug.
- instr_retiradas  output  ANCHO_CONT  retired-instruction count; wraps modulo 2^ANCHO_CONT.

Behaviour:
- Reset:
  - State becomes INICIO on the next edge; a reset asserted mid-instruction aborts it unconditionally.
  - In INICIO all outputs are 0, including mem_req and estado=0.
  - instr_retiradas=0, ilegal=0, error_cod=00.
- Outputs are a pure function of state. The only exception: ir_write and pc_write in FETCH are additionally gated by mem_listo.
- States and transitions:
  - INICIO -> FETCH, unconditionally.
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0. Stays until mem_listo. On mem_listo: ir_write=1, pc_write=1, go to DECODE.
  - DECODE: alu_src_a=1, alu_src_b=2, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - ld or sd -> DIR_MEM.
    - R-type -> EJEC_R.
    - beq -> RAMA.
    - any other opcode -> ERROR with error_cod=01.
  - DIR_MEM: alu_src_a=2, alu_src_b=2, alu_op=00. Goes to LEER_MEM for ld, ESCRIBIR_MEM for sd.
  - LEER_MEM: mem_req=1, iord=1. Waits for mem_listo, then goes to WB_MEM.
  - ESCRIBIR_MEM: mem_req=1, mem_write=1, iord=1. Waits for mem_listo, then retires and goes to FETCH.
  - WB_MEM: reg_write=1, mem_to_reg=1. Retires, goes to FETCH.
  - EJEC_R: alu_src_a=2, alu_src_b=0, alu_op=10. Goes to WB_R.
  - WB_R: reg_write=1, mem_to_reg=0. Retires, goes to FETCH.
  - RAMA: alu_src_a=2, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_src=1. Retires, goes to FETCH.
  - ERROR: all control outputs 0, ilegal=1, error_cod held. Only reset exits.
- Latency with zero memory wait:
  - beq: 3 cycles.
  - R-type: 4 cycles.
  - sd: 4 cycles.
  - ld: 5 cycles.
  - Each memory wait cycle adds 1.
- Retire: instr_retiradas increments by 1 on the edge leaving ESCRIBIR_MEM (with mem_listo), WB_MEM, WB_R or RAMA.
- Timeout:
  - The wait counter clears on entry to any memory state and increments each cycle mem_req=1 and mem_listo=0.
  - When it reaches MAX_ESPERA (MAX_ESPERA≠0) while mem_listo=0, the next state is ERROR with error_cod=10.
  - If mem_listo=1 in that same cycle, completion wins and no error is raised.
- mem_listo outside a memory state is ignored.
- The opcode input is sampled only in DECODE and DIR_MEM.

Decomposition:
- Package paquete_control holds:
  - the state enum (4-bit; INICIO=0, values fixed for debug);
  - opcode constants OP_LD, OP_SD, OP_BEQ, OP_R;
  - ALU_ADD, ALU_SUB, ALU_FUNCT;
  - the SRC_A_* and SRC_B_* select constants;
  - the ERR_* codes.
- One sub-module, contador_espera: parameterised MAX_ESPERA timeout counter with clear/enable inputs and an expired output.

Test Plan:
- Reset then release -> cycle 0: INICIO, all outputs 0. Cycle 1: FETCH, mem_req=1, iord=0.
- R-type (0110011), mem_listo high in FETCH -> states FETCH, DECODE, EJEC_R, WB_R over 4 cycles. reg_write=1 only in WB_R; alu_op=10 in EJEC_R; instr_retiradas goes 0→1.
- ld (0000011) with mem_listo delayed 3 cycles in LEER_MEM -> mem_req held 4 cycles with iord=1. WB_MEM asserts reg_write=1 and mem_to_reg=1. Total 8 cycles.
- beq (1100011) -> RAMA asserts pc_write_cond=1, pc_src=1, alu_op=01. Back to FETCH after 3 cycles.
- Opcode 0010011 -> after DECODE: ERROR, ilegal=1, error_cod=01. Stays put while clocking 20 cycles. Reset clears the error.
- MAX_ESPERA=4, mem_listo never asserted in FETCH -> ERROR with error_cod=10 after 4 wait cycles.
- Reset asserted during LEER_MEM -> INICIO next cycle, mem_req=0, counter=0.
